// File: rtl/back_icon_scheduler.sv
// Interconnect transfer scheduler: buffers (src, receiver-mask) transfers in a FIFO and issues
// them in order onto a pool of channels, tracking outstanding receivers and aborting stale channels.
module back_icon_scheduler #(
  parameter int NUM_ICON_CHANNELS = 4,
  parameter int NUM_EXEC_UNITS    = 4,
  parameter int SRC_W             = $clog2(NUM_EXEC_UNITS),
  parameter int NUM_RX            = 2*NUM_EXEC_UNITS+2,
  parameter int DEPTH             = 8,
  parameter int ISSUE_W           = 2,
  parameter int TIMEOUT           = 15,
  parameter int OCC_W             = $clog2(DEPTH)+1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [SRC_W-1:0]                    instr_src_i,
  input  logic [NUM_RX-1:0]                   instr_rcv_i,
  input  logic                                instr_valid_i,
  output logic                                instr_ready_o,
  output logic [NUM_ICON_CHANNELS-1:0]        ch_active_o,
  output logic [NUM_ICON_CHANNELS*SRC_W-1:0]  ch_src_addr_o,
  output logic [NUM_ICON_CHANNELS*NUM_RX-1:0] ch_rcv_list_o,
  input  logic [NUM_ICON_CHANNELS*NUM_RX-1:0] ch_success_i,
  output logic                                timeout_o,
  output logic [NUM_ICON_CHANNELS-1:0]        timeout_ch_o,
  output logic [OCC_W-1:0]                    occupancy_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int AGE_W = $clog2(TIMEOUT+1);
  localparam int CH_W  = (NUM_ICON_CHANNELS > 1) ? $clog2(NUM_ICON_CHANNELS) : 1;
  localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(TIMEOUT-1);

  logic [SRC_W-1:0]  fifo_src [DEPTH];
  logic [NUM_RX-1:0] fifo_rcv [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [OCC_W-1:0]  occ, occ_next, pop_cnt;
  logic              push;

  logic [NUM_ICON_CHANNELS-1:0] busy;
  logic [SRC_W-1:0]             ch_src   [NUM_ICON_CHANNELS];
  logic [NUM_RX-1:0]            ch_rem   [NUM_ICON_CHANNELS];
  logic [AGE_W-1:0]             ch_age   [NUM_ICON_CHANNELS];
  logic [NUM_RX-1:0]            rem_next [NUM_ICON_CHANNELS];
  logic [NUM_ICON_CHANNELS-1:0] done, abort;

  logic [NUM_ICON_CHANNELS-1:0] claim;
  logic [SRC_W-1:0]             claim_src [NUM_ICON_CHANNELS];
  logic [NUM_RX-1:0]            claim_rcv [NUM_ICON_CHANNELS];

  assign push     = instr_valid_i && instr_ready_o;
  assign occ_next = occ + OCC_W'(push) - pop_cnt;

  // In-order issue: each candidate is considered only while every earlier one went out.
  always_comb begin : issue_logic
    logic             stop, conflict, found;
    logic [CH_W-1:0]  sel;
    logic [PTR_W-1:0] idx;
    logic [SRC_W-1:0] c_src;
    logic [NUM_RX-1:0] c_rcv;
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    claim    = '0;
    pop_cnt  = '0;
    stop     = 1'b0;
    conflict = 1'b0;
    found    = 1'b0;
    sel      = '0;
    idx      = '0;
    c_src    = '0;
    c_rcv    = '0;
    for (int ch = 0; ch < NUM_ICON_CHANNELS; ch++) begin
      claim_src[ch] = '0;
      claim_rcv[ch] = '0;
    end
    for (int k = 0; k < ISSUE_W; k++) begin
      idx      = rd_ptr + PTR_W'(k);
      c_src    = fifo_src[idx];
      c_rcv    = fifo_rcv[idx];
      conflict = 1'b0;
      found    = 1'b0;
      sel      = '0;
      for (int ch = 0; ch < NUM_ICON_CHANNELS; ch++) begin
        if ((busy[ch] && ch_src[ch] == c_src) || (claim[ch] && claim_src[ch] == c_src))
          conflict = 1'b1;
        if (!found && !busy[ch] && !claim[ch]) begin
          found = 1'b1;
          sel   = CH_W'(ch);
        end
      end
      if (stop || OCC_W'(k) >= occ) begin
        stop = 1'b1;
      end else if (c_rcv == '0) begin
        pop_cnt = pop_cnt + OCC_W'(1);
      end else if (found && !conflict) begin
        claim[sel]     = 1'b1;
        claim_src[sel] = c_src;
        claim_rcv[sel] = c_rcv;
        pop_cnt        = pop_cnt + OCC_W'(1);
      end else begin
        stop = 1'b1;
      end
    end
  end

  // Done takes priority over abort when the last receiver succeeds on the final cycle.
  always_comb begin
    for (int ch = 0; ch < NUM_ICON_CHANNELS; ch++) begin
      rem_next[ch] = ch_rem[ch] & ~ch_success_i[ch*NUM_RX +: NUM_RX];
      done[ch]     = busy[ch] && (rem_next[ch] == '0);
      abort[ch]    = busy[ch] && (rem_next[ch] != '0) && (ch_age[ch] == AGE_LAST);
    end
  end

  // NOTE: the FIFO storage has no reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_src[wr_ptr] <= instr_src_i;
      fifo_rcv[wr_ptr] <= instr_rcv_i;
    end
  end

  // NOTE: all state below updates with non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      occ           <= '0;
      instr_ready_o <= 1'b1;
      busy          <= '0;
      timeout_o     <= 1'b0;
      timeout_ch_o  <= '0;
      for (int ch = 0; ch < NUM_ICON_CHANNELS; ch++) begin
        ch_src[ch] <= '0;
        ch_rem[ch] <= '0;
        ch_age[ch] <= '0;
      end
    end else begin
      rd_ptr        <= rd_ptr + PTR_W'(pop_cnt);
      wr_ptr        <= wr_ptr + PTR_W'(push);
      occ           <= occ_next;
      instr_ready_o <= (occ_next < OCC_W'(DEPTH));
      timeout_o     <= |abort;
      timeout_ch_o  <= abort;
      for (int ch = 0; ch < NUM_ICON_CHANNELS; ch++) begin
        if (done[ch] || abort[ch]) begin
          busy[ch]   <= 1'b0;
          ch_src[ch] <= '0;
          ch_rem[ch] <= '0;
          ch_age[ch] <= '0;
        end else if (busy[ch]) begin
          ch_rem[ch] <= rem_next[ch];
          ch_age[ch] <= ch_age[ch] + AGE_W'(1);
        end else if (claim[ch]) begin
          busy[ch]   <= 1'b1;
          ch_src[ch] <= claim_src[ch];
          ch_rem[ch] <= claim_rcv[ch];
          ch_age[ch] <= '0;
        end
      end
    end
  end

  assign ch_active_o = busy;
  assign occupancy_o = occ;

  for (genvar ch = 0; ch < NUM_ICON_CHANNELS; ch++) begin : g_out
    assign ch_src_addr_o[ch*SRC_W +: SRC_W]   = ch_src[ch];
    assign ch_rcv_list_o[ch*NUM_RX +: NUM_RX] = ch_rem[ch];
  end

endmodule

// File: tb/tb_back_icon_scheduler.sv
// Self-checking bench for back_icon_scheduler: directed scenarios plus random traffic,
// compared every cycle against a queue-based transfer model.
module tb_back_icon_scheduler;

  localparam int CH      = 4;
  localparam int NEU     = 4;
  localparam int SRC_W   = 2;
  localparam int NUM_RX  = 10;
  localparam int DEPTH   = 8;
  localparam int ISSUE_W = 2;
  localparam int TIMEOUT = 15;
  localparam int OCC_W   = 4;

  typedef struct packed {
    logic [SRC_W-1:0]  src;
    logic [NUM_RX-1:0] rcv;
  } xfer_t;

  logic                   clk;
  logic                   reset;
  logic [SRC_W-1:0]       instr_src_i;
  logic [NUM_RX-1:0]      instr_rcv_i;
  logic                   instr_valid_i;
  logic                   instr_ready_o;
  logic [CH-1:0]          ch_active_o;
  logic [CH*SRC_W-1:0]    ch_src_addr_o;
  logic [CH*NUM_RX-1:0]   ch_rcv_list_o;
  logic [CH*NUM_RX-1:0]   ch_success_i;
  logic                   timeout_o;
  logic [CH-1:0]          timeout_ch_o;
  logic [OCC_W-1:0]       occupancy_o;

  back_icon_scheduler #(
    .NUM_ICON_CHANNELS(CH), .NUM_EXEC_UNITS(NEU), .DEPTH(DEPTH),
    .ISSUE_W(ISSUE_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .instr_src_i(instr_src_i), .instr_rcv_i(instr_rcv_i),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
    .ch_active_o(ch_active_o), .ch_src_addr_o(ch_src_addr_o),
    .ch_rcv_list_o(ch_rcv_list_o), .ch_success_i(ch_success_i),
    .timeout_o(timeout_o), .timeout_ch_o(timeout_ch_o),
    .occupancy_o(occupancy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int saw_timeout = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: what each channel is doing and what is waiting, as plain arrays and a queue.
  xfer_t             m_fifo[$];
  bit                m_busy [CH];
  logic [SRC_W-1:0]  m_src  [CH];
  logic [NUM_RX-1:0] m_rem  [CH];
  int                m_age  [CH];
  logic [CH-1:0]     m_to;

  task automatic model_step();
    bit                was_busy [CH];
    bit                taken    [CH];
    logic [SRC_W-1:0]  t_src    [CH];
    logic [NUM_RX-1:0] t_rcv    [CH];
    logic [NUM_RX-1:0] left;
    int pops, free_ch;
    bit accept, clash;
    xfer_t e;
    if (reset) begin
      m_fifo.delete();
      m_to = '0;
      for (int c = 0; c < CH; c++) begin
        m_busy[c] = 0; m_src[c] = '0; m_rem[c] = '0; m_age[c] = 0;
      end
      return;
    end
    accept = instr_valid_i && (m_fifo.size() < DEPTH);
    pops = 0;
    for (int c = 0; c < CH; c++) begin
      was_busy[c] = m_busy[c]; taken[c] = 0; t_src[c] = '0; t_rcv[c] = '0;
    end
    for (int k = 0; k < ISSUE_W && k < m_fifo.size(); k++) begin
      e = m_fifo[k];
      if (e.rcv == '0) begin
        pops++;
        continue;
      end
      free_ch = -1;
      clash = 0;
      for (int c = 0; c < CH; c++) begin
        if (was_busy[c] && m_src[c] == e.src) clash = 1;
        if (taken[c] && t_src[c] == e.src) clash = 1;
        if (free_ch < 0 && !was_busy[c] && !taken[c]) free_ch = c;
      end
      if (free_ch < 0 || clash) break;
      taken[free_ch] = 1; t_src[free_ch] = e.src; t_rcv[free_ch] = e.rcv;
      pops++;
    end
    m_to = '0;
    for (int c = 0; c < CH; c++) begin
      if (was_busy[c]) begin
        left = m_rem[c] & ~ch_success_i[c*NUM_RX +: NUM_RX];
        if (left == '0 || m_age[c] == TIMEOUT-1) begin
          if (left != '0) m_to[c] = 1'b1;
          m_busy[c] = 0; m_src[c] = '0; m_rem[c] = '0; m_age[c] = 0;
        end else begin
          m_rem[c] = left;
          m_age[c]++;
        end
      end else if (taken[c]) begin
        m_busy[c] = 1; m_src[c] = t_src[c]; m_rem[c] = t_rcv[c]; m_age[c] = 0;
      end
    end
    repeat (pops) void'(m_fifo.pop_front());
    if (accept) m_fifo.push_back('{src: instr_src_i, rcv: instr_rcv_i});
  endtask

  task automatic compare_all();
    logic [CH-1:0]        e_act;
    logic [CH*SRC_W-1:0]  e_src;
    logic [CH*NUM_RX-1:0] e_rcv;
    for (int c = 0; c < CH; c++) begin
      e_act[c] = m_busy[c];
      e_src[c*SRC_W +: SRC_W]   = m_src[c];
      e_rcv[c*NUM_RX +: NUM_RX] = m_rem[c];
    end
    check("ch_active", 64'(ch_active_o), 64'(e_act));
    check("ch_src_addr", 64'(ch_src_addr_o), 64'(e_src));
    check("ch_rcv_list", 64'(ch_rcv_list_o), 64'(e_rcv));
    check("timeout", 64'(timeout_o), 64'(|m_to));
    check("timeout_ch", 64'(timeout_ch_o), 64'(m_to));
    check("occupancy", 64'(occupancy_o), 64'(m_fifo.size()));
    check("ready", 64'(instr_ready_o), 64'(m_fifo.size() < DEPTH));
    if (timeout_o) saw_timeout++;
  endtask

  task automatic step(input logic rst, input logic v, input logic [SRC_W-1:0] s,
                      input logic [NUM_RX-1:0] r, input logic [CH*NUM_RX-1:0] sc);
    reset = rst; instr_valid_i = v; instr_src_i = s; instr_rcv_i = r; ch_success_i = sc;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic push(input logic [SRC_W-1:0] s, input logic [NUM_RX-1:0] r);
    step(1'b0, 1'b1, s, r, '0);
  endtask

  initial begin
    logic [CH*NUM_RX-1:0] sc;
    logic [NUM_RX-1:0]    rr;
    reset = 1'b1; instr_valid_i = 1'b0; instr_src_i = '0; instr_rcv_i = '0; ch_success_i = '0;

    step(1'b1, 1'b0, '0, '0, '0);
    step(1'b1, 1'b0, '0, '0, '0);
    check("rst_ready", 64'(instr_ready_o), 64'd1);
    check("rst_occ", 64'(occupancy_o), 64'd0);
    check("rst_active", 64'(ch_active_o), 64'd0);

    // Single transfer, receivers succeed one at a time.
    push(2'd1, 10'h005);
    idle(1);
    check("t1_active", 64'(ch_active_o), 64'h1);
    check("t1_src", 64'(ch_src_addr_o[1:0]), 64'h1);
    check("t1_list", 64'(ch_rcv_list_o[9:0]), 64'h005);
    step(1'b0, 1'b0, '0, '0, 40'h001);
    check("t1_list_partial", 64'(ch_rcv_list_o[9:0]), 64'h004);
    step(1'b0, 1'b0, '0, '0, 40'h004);
    check("t1_done", 64'(ch_active_o), 64'h0);
    check("t1_no_timeout", 64'(timeout_o), 64'h0);

    // Same source back to back: second waits for the first to finish.
    push(2'd0, 10'h003);
    push(2'd0, 10'h00C);
    idle(1);
    check("t2_blocked", 64'(ch_active_o), 64'h1);
    step(1'b0, 1'b0, '0, '0, 40'h003);
    idle(1);
    check("t2_second_active", 64'(ch_active_o), 64'h1);
    check("t2_second_list", 64'(ch_rcv_list_o[9:0]), 64'h00C);
    step(1'b0, 1'b0, '0, '0, 40'h00C);

    // Fill every channel, then the FIFO, then let the channels time out.
    step(1'b1, 1'b0, '0, '0, '0);
    for (int i = 0; i < 6; i++) push(SRC_W'(i % 4), 10'h3FF);
    check("t3_all_busy", 64'(ch_active_o), 64'hF);
    check("t3_occ2", 64'(occupancy_o), 64'd2);
    for (int i = 0; i < 6; i++) push(SRC_W'(i), 10'h100);
    check("t3_full_ready", 64'(instr_ready_o), 64'd0);
    check("t3_full_occ", 64'(occupancy_o), 64'd8);
    push(2'd3, 10'h001);
    check("t3_ninth_dropped", 64'(occupancy_o), 64'd8);
    saw_timeout = 0;
    idle(40);
    check("t3_timeout_seen", 64'(saw_timeout > 0), 64'd1);

    // Empty transfer is discarded without occupying a channel.
    step(1'b1, 1'b0, '0, '0, '0);
    push(2'd0, 10'h000);
    push(2'd2, 10'h010);
    idle(1);
    check("t5_active", 64'(ch_active_o), 64'h1);
    check("t5_src", 64'(ch_src_addr_o[1:0]), 64'h2);
    check("t5_list", 64'(ch_rcv_list_o[9:0]), 64'h010);
    step(1'b0, 1'b0, '0, '0, 40'h010);

    // Random traffic with sparse successes and the occasional reset.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      sc = '0;
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 2) == 0) sc[c*NUM_RX +: NUM_RX] = NUM_RX'($urandom);
      rr = ($urandom_range(0, 7) == 0) ? '0 : NUM_RX'($urandom);
      step(($urandom_range(0, 399) == 0), ($urandom_range(0, 1) == 1),
           SRC_W'($urandom), rr, sc);
    end

    // Reset in the middle of activity.
    step(1'b1, 1'b0, '0, '0, '0);
    push(2'd0, 10'h001);
    push(2'd1, 10'h002);
    push(2'd2, 10'h004);
    push(2'd0, 10'h008);
    push(2'd1, 10'h010);
    push(2'd2, 10'h020);
    push(2'd0, 10'h040);
    check("t6_busy3", 64'(ch_active_o), 64'h7);
    check("t6_occ4", 64'(occupancy_o), 64'd4);
    step(1'b1, 1'b1, 2'd3, 10'h080, '0);
    check("t6_active", 64'(ch_active_o), 64'h0);
    check("t6_src", 64'(ch_src_addr_o), 64'h0);
    check("t6_list", 64'(ch_rcv_list_o), 64'h0);
    check("t6_occ", 64'(occupancy_o), 64'd0);
    check("t6_ready", 64'(instr_ready_o), 64'd1);
    check("t6_timeout", 64'(timeout_o), 64'd0);
    check("t6_timeout_ch", 64'(timeout_ch_o), 64'd0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
